instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// Instruction fetch unit: IDLE/FETCH/ISSUE sequencer holding one instruction for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a TRAP state and the misalign output.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
`endif

    state_t state;

    // Redirect address selection; without the trap the low bits are forced to word alignment.
    function automatic logic [31:0] next_pc(input logic        src,
                                            input logic [31:0] tgt,
                                            input logic [31:0] seq);
`ifdef FETCH_MISALIGN_TRAP_EN
        return src ? tgt : seq;
`else
        return src ? (tgt & 32'hFFFF_FFFC) : seq;
`endif
    endfunction

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign op        = instr[6:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Consumption happens only when downstream is not holding.
                    if (!stall) begin
                        instr       <= NOP_INSTR;
                        instr_valid <= 1'b0;
                        pc          <= next_pc(pc_src, pc_target, pc_plus4);
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (pc_src && (pc_target[1:0] != 2'b00)) begin
                            state    <= TRAP;
                            misalign <= 1'b1;
                            imem_req <= 1'b0;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
`else
                        state    <= FETCH;
                        imem_req <= 1'b1;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                TRAP: begin
                    state    <= TRAP;
                    imem_req <= 1'b0;
                end
`endif
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
